// File: rtl/cap_touch_channel.sv
// cap_touch_channel
// Single-pad capacitive touch sensor. The pad is driven low for a fixed number
// of enabled cycles and then released. The channel counts clocks until the
// external RC pull-up brings the synchronised pad level high. Each completed
// count is compared against a slowly tracking baseline of untouched counts,
// and a debounced touch flag with hysteresis is derived from the comparison.
module cap_touch_channel #(
  parameter int CNT_W            = 12,
  parameter int DISCHARGE_CYCLES = 16,
  parameter int TIMEOUT          = 4095,
  parameter int CAL_SHIFT        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             pad_in,
  output logic             pad_out,
  output logic             pad_oe,
  input  logic [7:0]       threshold,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic [CNT_W-1:0] baseline,
  output logic             touched,
  output logic             timeout
);

  localparam int DW = (DISCHARGE_CYCLES > 2) ? $clog2(DISCHARGE_CYCLES) : 2;
  localparam int CW = CNT_W + 8;
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [DW-1:0]    DISC_LAST = DW'(DISCHARGE_CYCLES - 1);

  // Reject parameter sets the measurement sequence cannot support.
  generate
    if (DISCHARGE_CYCLES < 3) begin : g_bad_discharge
      $error("cap_touch_channel: DISCHARGE_CYCLES must be at least 3");
    end
    if ((TIMEOUT < 0) || (longint'(TIMEOUT) > ((longint'(1) << CNT_W) - 64'sd1))) begin : g_bad_timeout
      $error("cap_touch_channel: TIMEOUT must fit in CNT_W bits");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_DISCHARGE = 2'd0,
    ST_MEASURE   = 2'd1,
    ST_EVAL      = 2'd2
  } state_t;

  // Positive part of (count - baseline); a count below the baseline never touches.
  function automatic logic [CNT_W-1:0] clamp_delta(input logic [CNT_W-1:0] c,
                                                   input logic [CNT_W-1:0] b);
    logic [CNT_W-1:0] r;
    if (c > b) begin
      r = c - b;
    end else begin
      r = {CNT_W{1'b0}};
    end
    return r;
  endfunction

  // Hysteretic touch decision: set at >= threshold, clear below threshold/2.
  function automatic logic touch_next(input logic             cur,
                                      input logic [CNT_W-1:0] delta,
                                      input logic [7:0]       thr);
    logic [CW-1:0] d_x;
    logic [CW-1:0] t_x;
    logic [CW-1:0] h_x;
    logic          r;
    d_x = {8'd0, delta};
    t_x = {{CNT_W{1'b0}}, thr};
    h_x = t_x >> 1;
    if (thr == 8'd0) begin
      r = 1'b0;
    end else if (!cur) begin
      r = (d_x >= t_x);
    end else if (d_x < h_x) begin
      r = 1'b0;
    end else begin
      r = 1'b1;
    end
    return r;
  endfunction

  // One IIR step toward the new count; floor shift keeps the result in range.
  function automatic logic [CNT_W-1:0] iir_step(input logic [CNT_W-1:0] b,
                                                input logic [CNT_W-1:0] c);
    logic signed [CNT_W:0] diff;
    logic signed [CNT_W:0] step;
    logic signed [CNT_W:0] sum;
    diff = $signed({1'b0, c}) - $signed({1'b0, b});
    step = diff >>> CAL_SHIFT;
    sum  = $signed({1'b0, b}) + step;
    return CNT_W'(sum);
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic             sync1_r;
  logic             pad_sync_r;
  logic [DW-1:0]    disc_cnt_r;
  logic [CNT_W-1:0] cnt_r;
  logic             calibrated_r;
  logic [CNT_W-1:0] count_r;
  logic             count_valid_r;
  logic [CNT_W-1:0] baseline_r;
  logic             touched_r;
  logic             timeout_r;
  logic             pad_oe_r;

  logic             disc_done_s;
  logic             cnt_at_max_s;
  logic             capture_s;
  logic [CNT_W-1:0] cap_val_s;
  logic             cap_to_s;
  logic             pad_oe_s;
  logic [CNT_W-1:0] delta_s;
  logic             touch_s;
  logic [CNT_W-1:0] base_s;
  logic             cal_s;

  assign disc_done_s  = (disc_cnt_r == DISC_LAST);
  assign cnt_at_max_s = (cnt_r == TIMEOUT_V);

  // Two-flop synchroniser: the only consumer of the raw pad level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r    <= 1'b0;
      pad_sync_r <= 1'b0;
    end else begin
      sync1_r    <= pad_in;
      pad_sync_r <= sync1_r;
    end
  end

  // Measurement sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_DISCHARGE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state: discharge until enough enabled cycles, measure until the pad rises or times out.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_DISCHARGE: begin
        if (ena && disc_done_s) begin
          state_s = ST_MEASURE;
        end else begin
          state_s = ST_DISCHARGE;
        end
      end
      ST_MEASURE: begin
        if (!ena) begin
          state_s = ST_DISCHARGE;
        end else if (pad_sync_r || cnt_at_max_s) begin
          state_s = ST_EVAL;
        end else begin
          state_s = ST_MEASURE;
        end
      end
      ST_EVAL: begin
        state_s = ST_DISCHARGE;
      end
      default: begin
        state_s = ST_DISCHARGE;
      end
    endcase
  end

  // Outputs of the sequencer: capture strobe, captured value and next pad drive.
  always_comb begin
    capture_s = 1'b0;
    cap_val_s = {CNT_W{1'b0}};
    cap_to_s  = 1'b0;
    pad_oe_s  = 1'b1;
    case (state_r)
      ST_MEASURE: begin
        if (!ena) begin
          capture_s = 1'b0;
        end else if (pad_sync_r) begin
          capture_s = 1'b1;
          cap_val_s = cnt_r;
        end else if (cnt_at_max_s) begin
          capture_s = 1'b1;
          cap_val_s = TIMEOUT_V;
          cap_to_s  = 1'b1;
        end else begin
          capture_s = 1'b0;
        end
      end
      default: begin
        capture_s = 1'b0;
      end
    endcase
    if (state_s == ST_DISCHARGE) begin
      pad_oe_s = 1'b1;
    end else begin
      pad_oe_s = 1'b0;
    end
  end

  // Discharge counter: counts enabled cycles, restarts on every entry to discharge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disc_cnt_r <= {DW{1'b0}};
    end else if ((state_r != ST_DISCHARGE) || (state_s != ST_DISCHARGE)) begin
      disc_cnt_r <= {DW{1'b0}};
    end else if (ena) begin
      disc_cnt_r <= disc_cnt_r + DW'(1'b1);
    end else begin
      disc_cnt_r <= disc_cnt_r;
    end
  end

  // Charge-time counter: runs only while the measurement continues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_MEASURE) && (state_s == ST_MEASURE)) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Evaluation of a captured count: calibrate once, then touch decision and baseline tracking.
  always_comb begin
    delta_s = clamp_delta(cap_val_s, baseline_r);
    touch_s = touched_r;
    base_s  = baseline_r;
    cal_s   = calibrated_r;
    if (!calibrated_r) begin
      base_s  = cap_val_s;
      cal_s   = 1'b1;
      touch_s = 1'b0;
    end else begin
      touch_s = touch_next(touched_r, delta_s, threshold);
      if (!touch_s && !cap_to_s) begin
        base_s = iir_step(baseline_r, cap_val_s);
      end else begin
        base_s = baseline_r;
      end
    end
  end

  // Result registers: all update together on the edge that enters evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_oe_r      <= 1'b1;
      count_valid_r <= 1'b0;
      count_r       <= {CNT_W{1'b0}};
      timeout_r     <= 1'b0;
      touched_r     <= 1'b0;
      baseline_r    <= {CNT_W{1'b0}};
      calibrated_r  <= 1'b0;
    end else begin
      pad_oe_r      <= pad_oe_s;
      count_valid_r <= capture_s;
      if (capture_s) begin
        count_r      <= cap_val_s;
        timeout_r    <= cap_to_s;
        touched_r    <= touch_s;
        baseline_r   <= base_s;
        calibrated_r <= cal_s;
      end else begin
        count_r      <= count_r;
        timeout_r    <= timeout_r;
        touched_r    <= touched_r;
        baseline_r   <= baseline_r;
        calibrated_r <= calibrated_r;
      end
    end
  end

  assign pad_out     = 1'b0;
  assign pad_oe      = pad_oe_r;
  assign count       = count_r;
  assign count_valid = count_valid_r;
  assign baseline    = baseline_r;
  assign touched     = touched_r;
  assign timeout     = timeout_r;

endmodule

// File: doc/cap_touch_channel.md
Name: cap_touch_channel

Overview:
- Single-channel capacitive touch sensor inside the user project. Consumes one bidirectional uio pad bit via the board-level I/O wrapper: `uio_in[n]` in, `uio_out[n]` / `uio_oe[n]` out.
- Repeats a cycle: actively discharges the pad, releases it, and counts clocks until the external RC pull-up drives the pad high.
- Tracks a slow baseline of untouched counts and asserts `touched`, with hysteresis, when a count exceeds the baseline by a threshold.

Parameters:
- CNT_W, 12, width of the charge-time counter, count and baseline.
- DISCHARGE_CYCLES, 16, cycles the pad is driven low before each measurement. Legal range ≥3; elaboration error otherwise.
- TIMEOUT, 4095, maximum count; a measurement reaching it is flagged as timeout. Must be ≤ 2^CNT_W-1.
- CAL_SHIFT, 3, baseline IIR shift: update weight is 1/2^CAL_SHIFT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  enable; low aborts the current measurement and holds the pad discharged
- pad_in  in  1  raw pad level (uio_in bit); asynchronous
- pad_out  out  1  pad drive value; constant 0
- pad_oe  out  1  pad output enable; 1 = drive low (discharge)
- threshold  in  8  touch threshold in counts, zero-extended; 0 disables touch detection
- count  out  CNT_W  last completed measurement
- count_valid  out  1  one-cycle pulse when count/touched/baseline update
- baseline  out  CNT_W  current untouched reference
- touched  out  1  debounced touch state
- timeout  out  1  last measurement hit TIMEOUT

Behaviour:
- Reset (async assert, sync release of state): state = DISCHARGE with its counter 0. `pad_oe` = 1, `pad_out` = 0. `count`, `count_valid`, `baseline`, `touched` and `timeout` are all 0. `calibrated` (internal) = 0. The 2-FF synchroniser clears to 0.
- `pad_in` passes through a 2-FF synchroniser producing `pad_sync`. No other logic uses raw `pad_in`.
- DISCHARGE:
  - `pad_oe` = 1.
  - The counter increments only while `ena` = 1.
  - After DISCHARGE_CYCLES enabled cycles, go to MEASURE with `cnt` = 0.
- MEASURE:
  - `pad_oe` = 0. Every cycle: if `pad_sync` = 1, capture `cnt` and go to EVAL; else if `cnt` = TIMEOUT, capture TIMEOUT, set `timeout_pending`, and go to EVAL; else `cnt++`.
  - If `pad_in` is first high during MEASURE cycle j (0-based), the reported count is j+2.
  - `ena` = 0 in any MEASURE cycle: return to DISCHARGE next cycle (`pad_oe` = 1 on the following cycle). No `count_valid` pulse; `count`, `baseline` and `touched` are unchanged.
- EVAL (one cycle), then DISCHARGE:
  - `count_valid` = 1 for this cycle. `count` and `timeout` are registered at entry and visible in this cycle.
  - If not `calibrated`: `baseline` = count, `calibrated` = 1, `touched` stays 0.
  - Otherwise, compute delta = count − baseline, clamped at 0 if negative:
    - threshold = 0 → `touched` = 0.
    - `touched` = 0 and delta ≥ threshold → `touched` = 1.
    - `touched` = 1 and delta < (threshold >> 1) → `touched` = 0.
    - In all other cases `touched` holds.
  - Baseline update happens only if the new `touched` = 0 and `timeout` = 0. The update is baseline += (count − baseline) >>> CAL_SHIFT, using a signed CNT_W+1-bit difference with an arithmetic (floor) shift; the result is CNT_W bits and cannot overflow.
  - All outputs are registered and change only on the EVAL edge, except `pad_oe`.
- Boundary cases:
  - `pad_in` stuck high gives count = 0 and is evaluated normally.
  - A timeout measurement still evaluates `touched`.
  - `ena` low during EVAL does not block EVAL; it completes.
  - Reset mid-operation returns to the reset state immediately; there is no partial update.

Test Plan:
- Reset then `ena` = 1, `pad_in` = 0 → `pad_oe` = 1 for exactly 16 cycles, then 0. Before that, `count`, `baseline`, `touched`, `timeout` and `count_valid` are all 0.
- First measurement with `pad_in` high from MEASURE cycle 98 → `count` = 100, single-cycle `count_valid`, `baseline` = 100, `touched` = 0, `pad_oe` back to 1 the next cycle.
- threshold = 20, baseline 100, successive counts:
  - 130 → `touched` = 1, baseline 100.
  - 112 → `touched` = 1 (12 ≥ 10).
  - 105 → `touched` = 0, baseline 100.
  - 116 → `touched` = 0, baseline 102.
  - 86 → baseline 100.
- `pad_in` held 0 → after `cnt` reaches 4095, `count` = 4095, `timeout` = 1, baseline unchanged. With threshold = 20 and baseline 100, `touched` = 1. A next normal measurement clears `timeout` to 0.
- Drop `ena` at MEASURE cycle 50 → `pad_oe` = 1 the next cycle, no `count_valid`, outputs unchanged. Re-raising `ena` gives a full 16-cycle discharge before the next MEASURE.
- Assert `rst_n` = 0 asynchronously mid-MEASURE while `touched` = 1 → `touched`, `baseline` and `count` read 0 and `pad_oe` = 1 before the next clock edge. The next measurement recalibrates the baseline.
